// File: rtl/rom_loader.sv
// Boot copy engine: streams the program ROM into main memory, then releases the CPU from reset.
// Latency: start sampled in cycle 0, first write request in cycle 2, 2 cycles per byte with mem_ready_i high.
// Backpressure: a write is held with stable address/data while mem_ready_i is low; each stall cycle adds one cycle.
module rom_loader #(
   parameter logic [31:0] BASE_ADDRESS = 32'd0,
   parameter logic [31:0] MAX_BYTES    = 32'd65536
) (
   input  logic        clock_i,
   input  logic        reset_i,
   input  logic        start_i,
   output logic [31:0] rom_address_o,
   input  logic [7:0]  rom_byte_i,
   input  logic        rom_done_i,
   output logic [31:0] mem_address_o,
   output logic [7:0]  mem_data_o,
   output logic        mem_write_o,
   input  logic        mem_ready_i,
   output logic        busy_o,
   output logic        load_complete_o,
   output logic        cpu_reset_o,
   output logic        error_o,
   output logic [7:0]  checksum_o,
   output logic [31:0] byte_count_o
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_READ  = 3'd1,
      S_WRITE = 3'd2,
      S_DONE  = 3'd3,
      S_ERROR = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] rom_address_q, rom_address_d;
   logic [31:0] mem_address_q, mem_address_d;
   logic [7:0]  mem_data_q, mem_data_d;
   logic        last_q, last_d;
   logic [7:0]  checksum_q, checksum_d;
   logic [31:0] byte_count_q, byte_count_d;

   // Status flags are registered copies decoded from the next state, so every
   // output is a flop and there is no input-to-output combinational path.
   logic        mem_write_q, mem_write_d;
   logic        busy_q, busy_d;
   logic        load_complete_q, load_complete_d;
   logic        cpu_reset_q, cpu_reset_d;
   logic        error_q, error_d;

   // State register and datapath registers; reset abandons any pending write.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q         <= S_IDLE;
         rom_address_q   <= '0;
         mem_address_q   <= '0;
         mem_data_q      <= '0;
         last_q          <= 1'b0;
         checksum_q      <= '0;
         byte_count_q    <= '0;
         mem_write_q     <= 1'b0;
         busy_q          <= 1'b0;
         load_complete_q <= 1'b0;
         cpu_reset_q     <= 1'b1;
         error_q         <= 1'b0;
      end else begin
         state_q         <= state_d;
         rom_address_q   <= rom_address_d;
         mem_address_q   <= mem_address_d;
         mem_data_q      <= mem_data_d;
         last_q          <= last_d;
         checksum_q      <= checksum_d;
         byte_count_q    <= byte_count_d;
         mem_write_q     <= mem_write_d;
         busy_q          <= busy_d;
         load_complete_q <= load_complete_d;
         cpu_reset_q     <= cpu_reset_d;
         error_q         <= error_d;
      end
   end

   // Next-state and datapath updates: READ captures one ROM byte, WRITE waits for acceptance.
   always_comb begin
      state_d       = state_q;
      rom_address_d = rom_address_q;
      mem_address_d = mem_address_q;
      mem_data_d    = mem_data_q;
      last_d        = last_q;
      checksum_d    = checksum_q;
      byte_count_d  = byte_count_q;

      unique case (state_q)
         S_IDLE: begin
            rom_address_d = '0;
            if (start_i) begin
               state_d = S_READ;
            end
         end

         S_READ: begin
            // rom_byte_i/rom_done_i are combinational from the registered address,
            // which has been stable since the previous edge.
            mem_data_d    = rom_byte_i;
            mem_address_d = BASE_ADDRESS + rom_address_q;
            last_d        = rom_done_i;
            state_d       = S_WRITE;
         end

         S_WRITE: begin
            if (mem_ready_i) begin
               checksum_d   = checksum_q + mem_data_q;
               byte_count_d = byte_count_q + 32'd1;
               // The final image byte wins over the length limit: an image of
               // exactly MAX_BYTES bytes still completes normally.
               if (last_q) begin
                  state_d = S_DONE;
               end else if (byte_count_d == MAX_BYTES) begin
                  state_d = S_ERROR;
               end else begin
                  rom_address_d = rom_address_q + 32'd1;
                  state_d       = S_READ;
               end
            end
         end

         S_DONE: begin
            state_d = S_DONE;
         end

         S_ERROR: begin
            state_d = S_ERROR;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Moore status decode from the next state, registered alongside it.
   always_comb begin
      mem_write_d     = (state_d == S_WRITE);
      busy_d          = (state_d == S_READ) || (state_d == S_WRITE);
      load_complete_d = (state_d == S_DONE);
      error_d         = (state_d == S_ERROR);
      cpu_reset_d     = (state_d != S_DONE);
   end

   assign rom_address_o   = rom_address_q;
   assign mem_address_o   = mem_address_q;
   assign mem_data_o      = mem_data_q;
   assign mem_write_o     = mem_write_q;
   assign busy_o          = busy_q;
   assign load_complete_o = load_complete_q;
   assign cpu_reset_o     = cpu_reset_q;
   assign error_o         = error_q;
   assign checksum_o      = checksum_q;
   assign byte_count_o    = byte_count_q;

endmodule

// File: tb/tb_rom_loader.sv
// Bench for rom_loader: two instances (default parameters, and base 0x1000 with a 5-byte limit)
// driven one at a time from a stub ROM, with random stalls and ignored-input noise.
// Expected writes, timing, checksum and final status come from a per-image arithmetic model.
module tb_rom_loader;

   localparam logic [31:0] BASE1 = 32'h0000_1000;
   localparam logic [31:0] MAX1  = 32'd5;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset         [2];
   logic        start         [2];
   logic        mem_ready     [2];
   logic [31:0] rom_address   [2];
   logic [7:0]  rom_byte      [2];
   logic        rom_done      [2];
   logic [31:0] mem_address   [2];
   logic [7:0]  mem_data      [2];
   logic        mem_write     [2];
   logic        busy          [2];
   logic        load_complete [2];
   logic        cpu_reset     [2];
   logic        error         [2];
   logic [7:0]  checksum      [2];
   logic [31:0] byte_count    [2];

   // Stub ROM shared by both instances (only one is active at a time).
   logic [7:0]  rom_img [0:255];
   int          done_idx;

   assign rom_byte[0] = rom_img[rom_address[0][7:0]];
   assign rom_byte[1] = rom_img[rom_address[1][7:0]];
   assign rom_done[0] = (done_idx >= 0) && (rom_address[0] == 32'(done_idx));
   assign rom_done[1] = (done_idx >= 0) && (rom_address[1] == 32'(done_idx));

   rom_loader u_dut0 (
      .clock_i(clk), .reset_i(reset[0]), .start_i(start[0]),
      .rom_address_o(rom_address[0]), .rom_byte_i(rom_byte[0]), .rom_done_i(rom_done[0]),
      .mem_address_o(mem_address[0]), .mem_data_o(mem_data[0]), .mem_write_o(mem_write[0]),
      .mem_ready_i(mem_ready[0]), .busy_o(busy[0]), .load_complete_o(load_complete[0]),
      .cpu_reset_o(cpu_reset[0]), .error_o(error[0]), .checksum_o(checksum[0]),
      .byte_count_o(byte_count[0])
   );

   rom_loader #(.BASE_ADDRESS(BASE1), .MAX_BYTES(MAX1)) u_dut1 (
      .clock_i(clk), .reset_i(reset[1]), .start_i(start[1]),
      .rom_address_o(rom_address[1]), .rom_byte_i(rom_byte[1]), .rom_done_i(rom_done[1]),
      .mem_address_o(mem_address[1]), .mem_data_o(mem_data[1]), .mem_write_o(mem_write[1]),
      .mem_ready_i(mem_ready[1]), .busy_o(busy[1]), .load_complete_o(load_complete[1]),
      .cpu_reset_o(cpu_reset[1]), .error_o(error[1]), .checksum_o(checksum[1]),
      .byte_count_o(byte_count[1])
   );

   int checks   = 0;
   int failures = 0;

   // Reference model of one load, from the image and the chosen stall pattern.
   int          stall_q  [0:63];
   int          acc_cyc  [0:63];
   logic [31:0] exp_addr [0:63];
   logic [7:0]  exp_data [0:63];
   logic [7:0]  exp_ck   [0:64];
   int          n_exp;
   bit          exp_done;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic build_model(input logic [31:0] base, input logic [31:0] maxb);
      longint limit;
      int     cyc;
      limit = (done_idx >= 0) ? longint'(done_idx) + 1 : 64'd1 << 40;
      if (limit <= longint'(maxb)) begin
         n_exp    = int'(limit);
         exp_done = 1'b1;
      end else begin
         n_exp    = int'(maxb);
         exp_done = 1'b0;
      end
      cyc       = 0;
      exp_ck[0] = 8'h00;
      for (int i = 0; i < n_exp; i++) begin
         cyc         = cyc + 2 + stall_q[i];
         acc_cyc[i]  = cyc;
         exp_addr[i] = base + 32'(i);
         exp_data[i] = rom_img[i];
         exp_ck[i+1] = exp_ck[i] + rom_img[i];
      end
   endtask

   function automatic int acc_before(input int c);
      int n = 0;
      for (int i = 0; i < n_exp; i++)
         if (acc_cyc[i] < c) n++;
      return n;
   endfunction

   function automatic bit in_write(input int c);
      for (int i = 0; i < n_exp; i++)
         if (c >= acc_cyc[i] - stall_q[i] && c <= acc_cyc[i]) return 1'b1;
      return 1'b0;
   endfunction

   task automatic clear_stalls();
      for (int i = 0; i < 64; i++) stall_q[i] = 0;
   endtask

   task automatic check_reset_vals(input int d, input string tag);
      chk({tag, " rom_address"},   rom_address[d],   32'h0);
      chk({tag, " mem_address"},   mem_address[d],   32'h0);
      chk({tag, " mem_data"},      mem_data[d],      32'h0);
      chk({tag, " mem_write"},     mem_write[d],     32'h0);
      chk({tag, " busy"},          busy[d],          32'h0);
      chk({tag, " load_complete"}, load_complete[d], 32'h0);
      chk({tag, " error"},         error[d],         32'h0);
      chk({tag, " checksum"},      checksum[d],      32'h0);
      chk({tag, " byte_count"},    byte_count[d],    32'h0);
      chk({tag, " cpu_reset"},     cpu_reset[d],     32'h1);
   endtask

   // One reset cycle, then two idle cycles with start low and mem_ready noise.
   task automatic do_reset(input int d, input string tag);
      @(negedge clk);
      reset[d] = 1'b1; start[d] = 1'b0; mem_ready[d] = 1'b0;
      @(negedge clk);
      reset[d] = 1'b0;
      check_reset_vals(d, {tag, " rst"});
      for (int i = 0; i < 2; i++) begin
         mem_ready[d] = 1'($urandom_range(0, 1));
         @(negedge clk);
         chk({tag, " idle busy"},      busy[d],      32'h0);
         chk({tag, " idle mem_write"}, mem_write[d], 32'h0);
      end
      mem_ready[d] = 1'b0;
   endtask

   // Start pulse in cycle 0, then cycle-by-cycle comparison against the model.
   task automatic run_case(input int d, input string name);
      logic [31:0] base, maxb;
      int last_acc, k, stall_left, nwrites, comp_cyc, kw;
      bit fin;
      base = (d == 1) ? BASE1 : 32'd0;
      maxb = (d == 1) ? MAX1  : 32'd65536;
      build_model(base, maxb);
      last_acc   = acc_cyc[n_exp-1];
      k          = 0;
      stall_left = stall_q[0];
      nwrites    = 0;
      comp_cyc   = -1;
      @(negedge clk);
      start[d]     = 1'b1;
      mem_ready[d] = 1'($urandom_range(0, 1));
      for (int c = 1; c <= last_acc + 6; c++) begin
         @(negedge clk);
         // start is ignored outside IDLE; the DUT has left IDLE by now.
         start[d] = 1'($urandom_range(0, 1));
         kw  = acc_before(c);
         fin = (c > last_acc);
         chk($sformatf("%s c%0d busy", name, c),          busy[d],          32'(!fin));
         chk($sformatf("%s c%0d mem_write", name, c),     mem_write[d],     32'(in_write(c)));
         chk($sformatf("%s c%0d byte_count", name, c),    byte_count[d],    32'(kw));
         chk($sformatf("%s c%0d checksum", name, c),      checksum[d],      32'(exp_ck[kw]));
         chk($sformatf("%s c%0d load_complete", name, c), load_complete[d], 32'(exp_done && fin));
         chk($sformatf("%s c%0d error", name, c),         error[d],         32'(!exp_done && fin));
         chk($sformatf("%s c%0d cpu_reset", name, c),     cpu_reset[d],     32'(!(exp_done && fin)));
         if (comp_cyc < 0 && (load_complete[d] === 1'b1 || error[d] === 1'b1)) comp_cyc = c;
         if (mem_write[d] === 1'b1) begin
            if (kw < n_exp) begin
               chk($sformatf("%s c%0d mem_address", name, c), mem_address[d], exp_addr[kw]);
               chk($sformatf("%s c%0d mem_data", name, c),    mem_data[d],    32'(exp_data[kw]));
            end
            if (stall_left > 0) begin
               mem_ready[d] = 1'b0;
               stall_left--;
            end else begin
               mem_ready[d] = 1'b1;
               nwrites++;
               k++;
               stall_left = (k < 64) ? stall_q[k] : 0;
            end
         end else begin
            mem_ready[d] = 1'($urandom_range(0, 1));
         end
      end
      chk({name, " writes"},         32'(nwrites),   32'(n_exp));
      chk({name, " complete cycle"}, 32'(comp_cyc),  32'(last_acc + 1));
      chk({name, " rom_address"},    rom_address[d], 32'(n_exp - 1));
      start[d]     = 1'b0;
      mem_ready[d] = 1'b0;
   endtask

   task automatic load_img(input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3, input int di);
      rom_img[0] = b0; rom_img[1] = b1; rom_img[2] = b2; rom_img[3] = b3;
      done_idx   = di;
   endtask

   initial begin
      bit found;
      for (int i = 0; i < 256; i++) rom_img[i] = 8'($urandom);
      done_idx = 0;
      clear_stalls();
      for (int d = 0; d < 2; d++) begin
         reset[d] = 1'b1; start[d] = 1'b0; mem_ready[d] = 1'b0;
      end
      repeat (2) @(negedge clk);
      check_reset_vals(0, "init0");
      check_reset_vals(1, "init1");
      reset[0] = 1'b0; reset[1] = 1'b0;

      // Four-byte image, no stalls: writes in cycles 2/4/6/8, done from cycle 9.
      load_img(8'h11, 8'h22, 8'h33, 8'h44, 3);
      run_case(0, "t1");
      chk("t1 checksum",   checksum[0],   32'hAA);
      chk("t1 byte_count", byte_count[0], 32'd4);
      do_reset(0, "t1");

      // Same image at base 0x1000 with a 3-cycle stall on the second write.
      load_img(8'h11, 8'h22, 8'h33, 8'h44, 3);
      clear_stalls();
      stall_q[1] = 3;
      run_case(1, "t2");
      chk("t2 checksum", checksum[1], 32'hAA);
      clear_stalls();
      do_reset(1, "t2");

      // No done marker: stop on the 5-byte limit with error.
      for (int i = 0; i < 8; i++) rom_img[i] = 8'($urandom);
      done_idx = -1;
      run_case(1, "t3");
      chk("t3 error",         error[1],         32'h1);
      chk("t3 cpu_reset",     cpu_reset[1],     32'h1);
      chk("t3 load_complete", load_complete[1], 32'h0);
      chk("t3 byte_count",    byte_count[1],    32'd5);
      do_reset(1, "t3");

      // Reset while the third byte (address 2) is stalled in WRITE.
      load_img(8'h11, 8'h22, 8'h33, 8'h44, 3);
      found = 1'b0;
      @(negedge clk);
      start[0] = 1'b1; mem_ready[0] = 1'b1;
      for (int c = 1; c < 20 && !found; c++) begin
         @(negedge clk);
         start[0] = 1'b0;
         if (mem_write[0] === 1'b1 && byte_count[0] === 32'd2) begin
            mem_ready[0] = 1'b0;
            reset[0]     = 1'b1;
            found        = 1'b1;
         end
      end
      chk("t4 reached byte 2", 32'(found), 32'h1);
      @(negedge clk);
      reset[0] = 1'b0;
      check_reset_vals(0, "t4 abort");
      run_case(0, "t4 reload");
      do_reset(0, "t4");

      // Single-byte image; start noise in DONE must not restart.
      load_img(8'h7F, 8'h55, 8'h66, 8'h77, 0);
      run_case(0, "t5");
      chk("t5 checksum",   checksum[0],   32'h7F);
      chk("t5 byte_count", byte_count[0], 32'd1);
      do_reset(0, "t5");

      // Checksum wraps modulo 256.
      load_img(8'hFF, 8'hFF, 8'h03, 8'h00, 2);
      run_case(0, "t6");
      chk("t6 checksum",   checksum[0],   32'h01);
      chk("t6 byte_count", byte_count[0], 32'd3);
      do_reset(0, "t6");

      // Random images and stall patterns on the default instance.
      for (int r = 0; r < 8; r++) begin
         for (int i = 0; i < 32; i++) rom_img[i] = 8'($urandom);
         for (int i = 0; i < 64; i++)
            stall_q[i] = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 3)) : 0;
         done_idx = int'($urandom_range(0, 23));
         run_case(0, $sformatf("r0_%0d", r));
         do_reset(0, "r0");
      end

      // Random images around the 5-byte limit on the based instance.
      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < 32; i++) rom_img[i] = 8'($urandom);
         for (int i = 0; i < 64; i++)
            stall_q[i] = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 2)) : 0;
         done_idx = int'($urandom_range(0, 8)) - 1;
         run_case(1, $sformatf("r1_%0d", r));
         do_reset(1, "r1");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rom_loader.md
# rom_loader

Boot-time copy engine that sits directly downstream of the generated program ROM. On `start` it walks the ROM's byte address from 0 and writes each byte into main memory through a ready/valid write port. It stops after the byte at which the ROM raises `done`, and only then releases the CPU from reset. It also reports a running byte count and an 8-bit additive checksum so boot can be verified.

## Interface
- `BASE_ADDRESS`, default 32'd0: memory address that receives ROM byte 0.
- `MAX_BYTES`, default 32'd65536: byte-count limit without ROM `done`; reaching it means error.

- `clock`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  begin load; sampled only in IDLE.
- `rom_address`  out  32  byte address driven to the ROM (registered).
- `rom_byte`  in  8  ROM data, combinational from `rom_address`.
- `rom_done`  in  1  high when `rom_address` is the last image byte.
- `mem_address`  out  32  write address.
- `mem_data`  out  8  write data.
- `mem_write`  out  1  write request.
- `mem_ready`  in  1  memory accepts the write in a cycle with `mem_write && mem_ready`.
- `busy`  out  1  high in READ and WRITE.
- `load_complete`  out  1  sticky high in DONE.
- `cpu_reset`  out  1  holds the CPU in reset; low only in DONE.
- `error`  out  1  sticky high in ERROR.
- `checksum`  out  8  sum of accepted bytes, mod 256.
- `byte_count`  out  32  number of accepted writes.

## Operation
- FSM states: IDLE, READ, WRITE, DONE, ERROR.
- IDLE
  - `rom_address`=0.
  - `start`=1 → READ. Otherwise stay.
- READ
  - Latch `mem_data`←`rom_byte`.
  - Latch `mem_address`←`BASE_ADDRESS`+`rom_address`, mod 2^32.
  - Latch `last`←`rom_done`.
  - → WRITE.
- WRITE
  - `mem_write`=1, held with stable address and data until accepted.
  - On accept:
    - `checksum`+=`mem_data`, 8-bit wrap.
    - `byte_count`+=1.
    - If `last` → DONE.
    - Else if new `byte_count`==`MAX_BYTES` → ERROR.
    - Else `rom_address`+=1 and → READ.
  - `mem_ready` low: stay in WRITE with no state change.
- DONE
  - `load_complete`=1, `cpu_reset`=0, `busy`=0.
  - Terminal until `reset`.
- ERROR
  - `error`=1, `cpu_reset`=1, `busy`=0.
  - Terminal until `reset`.
- The byte at the `rom_done` address is written; the image length is that address+1.
- `start` is ignored outside IDLE. `mem_ready` is ignored outside WRITE.
- `rom_done` is sampled only in READ.
- Reset mid-operation: any pending write is abandoned and all registers return to their reset values. There is no partial-complete indication.

## Timing
- Reset values:
  - `rom_address`=0, `mem_address`=0, `mem_data`=0.
  - `mem_write`=0, `busy`=0, `load_complete`=0, `error`=0.
  - `checksum`=0, `byte_count`=0.
  - `cpu_reset`=1.
  - State IDLE.
- All outputs are registered (Moore); no combinational path from inputs to outputs.
- `start` sampled high in cycle 0 → READ in cycle 1 → `mem_write` high in cycle 2.
- With `mem_ready` tied high: 2 cycles per byte.
  - N-byte image: final accept in cycle 2N.
  - `load_complete`=1 and `cpu_reset`=0 from cycle 2N+1.
- Each cycle with `mem_ready` low in WRITE adds one cycle.
- `checksum` and `byte_count` update in the cycle after each accept.
- `rom_address` advances one cycle after an accept. The ROM output is valid combinationally in the following READ cycle.

## Test plan
1. Stub ROM of 4 bytes {0x11,0x22,0x33,0x44} with `rom_done` at address 3, `mem_ready`=1, `start` pulsed in cycle 0.
   - Writes (0,0x11) (1,0x22) (2,0x33) (3,0x44) in cycles 2, 4, 6, 8.
   - `checksum`=0xAA, `byte_count`=4.
   - `load_complete`=1 and `cpu_reset`=0 from cycle 9.
2. Same stub with `BASE_ADDRESS`=0x1000 and `mem_ready` low for 3 cycles on the second write.
   - `mem_write`, `mem_address`=0x1001 and `mem_data`=0x22 are held stable throughout the stall.
   - Completion occurs 3 cycles later than in test 1.
3. Stub ROM with `rom_done` never asserted, `MAX_BYTES`=5.
   - Exactly 5 writes.
   - Then `error`=1, `cpu_reset`=1, `load_complete`=0, `byte_count`=5.
4. `reset` asserted while in WRITE on byte 2 with `mem_ready`=0.
   - Next cycle: all outputs at reset values, state IDLE.
   - A fresh `start` reloads from address 0.
5. Single-byte image (`rom_done` at address 0, byte 0x7F).
   - One write.
   - `checksum`=0x7F, `load_complete` in cycle 3.
   - `start` pulsed again in DONE causes no further writes.
6. Checksum wrap: 3 bytes {0xFF,0xFF,0x03}.
   - `checksum`=0x01, `byte_count`=3.
